// File: rtl/muldiv_unit_if.sv
// Request / writeback bundle between decode, muldiv_unit and the register bank.
//   start, op, a, b, rd     : request from decode (master drives)
//   busy                    : unit occupied, PC stall
//   done, div_by_zero       : one-cycle status pulses in the writeback cycle
//   reg_we, reg_waddr,
//   reg_wdata               : register bank write port
interface muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [AW-1:0]    rd;
  logic             busy;
  logic             done;
  logic             reg_we;
  logic [AW-1:0]    reg_waddr;
  logic [WIDTH-1:0] reg_wdata;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, rd,
    input  busy, done, reg_we, reg_waddr, reg_wdata, div_by_zero
  );

  modport slave (
    input  start, op, a, b, rd,
    output busy, done, reg_we, reg_waddr, reg_wdata, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply / divide unit (MUL, MULH, DIV, REM).
// Operands are latched as magnitudes plus sign bits; WIDTH radix-2 steps run
// in CALC (shift-add for multiply, restoring shift-subtract for divide), then
// a single WB cycle presents the sign-corrected result to the register bank.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : muldiv_unit_if slave (request in, busy/done/write port out)
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [AW-1:0]      rd_q;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               busy_q;
  logic               done_q;
  logic               we_q;
  logic [AW-1:0]      waddr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               dbz_q;

  // Combinational step / result logic
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   result;

  always_comb begin
    abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Multiply: low half of prod holds the remaining multiplier bits, high
    // half accumulates; the carry out of the add shifts into the top.
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
    prod_nx = {mul_sum, prod[WIDTH-1:1]};

    // Restoring divide: quo shifts dividend bits out the top and quotient
    // bits in at the bottom.
    div_sh   = {rem, quo[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_b};
    div_ge   = (div_sh >= {1'b0, mag_b});
    rem_nx   = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    quo_nx   = {quo[WIDTH-2:0], div_ge};

    // Results are formed from the step's next values so they can be
    // registered on the same edge as the final step.
    prod_fix = (sign_a ^ sign_b) ? -prod_nx : prod_nx;
    quo_fix  = (sign_a ^ sign_b) ? -quo_nx  : quo_nx;
    rem_fix  = sign_a ? -rem_nx : rem_nx;
    a_orig   = sign_a ? -mag_a  : mag_a;

    unique case (op_q)
      2'b00:   result = prod_fix[WIDTH-1:0];
      2'b01:   result = prod_fix[2*WIDTH-1:WIDTH];
      2'b10:   result = b_zero ? '1 : quo_fix;
      default: result = b_zero ? a_orig : rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      b_zero  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            rd_q   <= bus.rd;
            sign_a <= bus.a[WIDTH-1];
            sign_b <= bus.b[WIDTH-1];
            b_zero <= (bus.b == '0);
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            prod   <= {{WIDTH{1'b0}}, abs_b};
            rem    <= '0;
            quo    <= abs_a;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          prod  <= prod_nx;
          rem   <= rem_nx;
          quo   <= quo_nx;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            done_q  <= 1'b1;
            we_q    <= (rd_q != '0);
            waddr_q <= rd_q;
            wdata_q <= result;
            dbz_q   <= op_q[1] & b_zero;
            state   <= WB;
          end
        end
        WB: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          dbz_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.reg_we      = we_q;
  assign bus.reg_waddr   = waddr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  muldiv_unit_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: signed arithmetic on 64-bit integers, truncating division.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    pu = p;
    case (op)
      2'b00: return pu[31:0];
      2'b01: return pu[63:32];
      2'b10: begin
        if (sb == 0) return '1;
        q = sa / sb;          // min / -1 yields +2^31, truncated to 0x80000000
        return WIDTH'(q);
      end
      default: begin
        if (sb == 0) return a;
        r = sa % sb;
        return WIDTH'(r);
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [AW-1:0] rd,
                        input bit mid_start);
    logic [WIDTH-1:0] exp;
    int cycles;
    exp = model(op, a, b);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.rd = rd;
    tick();                             // E0
    check("busy_after_accept", bus.busy, 1);
    bus.start = 1'b0;
    // Operand changes after acceptance must not matter.
    bus.a  = $urandom;
    bus.b  = $urandom;
    bus.rd = AW'($urandom);
    bus.op = 2'($urandom);
    cycles = 0;
    while (!bus.done && cycles < WIDTH + 8) begin
      tick();
      cycles++;
      bus.start = (mid_start && cycles == 5);
      if (!bus.done) begin
        if (bus.reg_we !== 1'b0 || bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
          check("calc_outputs", {bus.reg_we, bus.div_by_zero, bus.busy}, 3'b001);
        end
      end
    end
    bus.start = 1'b0;
    check("latency", cycles, WIDTH);
    check("done", bus.done, 1);
    check("busy_in_wb", bus.busy, 1);
    check("waddr", bus.reg_waddr, rd);
    check("wdata", bus.reg_wdata, exp);
    check("reg_we", bus.reg_we, (rd != 0));
    check("div_by_zero", bus.div_by_zero, (op[1] && b == 0));
    tick();                             // E_WIDTH+1
    check("busy_after_wb", bus.busy, 0);
    check("done_after_wb", bus.done, 0);
    check("we_after_wb", bus.reg_we, 0);
    check("wdata_hold", bus.reg_wdata, exp);
    if (mid_start) begin
      cycles = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (bus.done || bus.busy) cycles++;
      end
      check("mid_start_ignored", cycles, 0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [1:0] rop;
    int extra;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.rd = '0;
    reset = 1'b1;
    tick();
    tick();
    check("rst_outputs",
          {bus.busy, bus.done, bus.reg_we, bus.div_by_zero, bus.reg_waddr, bus.reg_wdata},
          '0);
    reset = 1'b0;
    tick();

    run_op(2'b00, 32'd7, -32'sd3, 5'd4, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd5, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd5, 1'b0);
    run_op(2'b10, -32'sd7, 32'd2, 5'd6, 1'b0);
    run_op(2'b11, -32'sd7, 32'd2, 5'd6, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b0);
    run_op(2'b10, 32'd100, 32'd0, 5'd7, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 5'd7, 1'b0);
    run_op(2'b11, -32'sd100, 32'd0, 5'd7, 1'b0);
    run_op(2'b00, 32'd5, 32'd5, 5'd0, 1'b1);

    // Reset mid-operation: sampled high at E10 aborts with no writeback.
    bus.start = 1'b1;
    bus.op = 2'b10;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    bus.rd = 5'd9;
    tick();                             // E0
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick(); // E1..E9
    reset = 1'b1;
    tick();                             // E10
    check("abort_outputs",
          {bus.busy, bus.done, bus.reg_we, bus.div_by_zero, bus.reg_waddr, bus.reg_wdata},
          '0);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      tick();
      if (bus.done || bus.reg_we || bus.busy) extra++;
    end
    check("abort_no_wb", extra, 0);
    run_op(2'b00, 32'd3, 32'd4, 5'd1, 1'b0);

    // Randomized operations with a bias towards edge operands.
    for (int n = 0; n < 30; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 32'h8000_0000;
        3: rb = WIDTH'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, AW'($urandom), (n % 7 == 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
